// File: rtl/qerv_dbus_ram.sv
// Word-organised RAM terminating the core's Wishbone-style data bus.
// Returns read data with a single-cycle ack after WAIT_STATES extra cycles.
module qerv_dbus_ram #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   rdt_q;
  logic          ack_q;
  logic [31:0]   mem_q [DEPTH/4];
  logic [AW-3:0] idx;

  assign idx      = i_wb_adr[AW-1:2];
  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;

  // Byte offset and bits above the RAM size are deliberately ignored (address wrap).
  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdt_q   <= 32'd0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= 1'b0;
          if (i_wb_cyc) begin
            if (WAIT_STATES == 0) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
              rdt_q   <= mem_q[idx];
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        StWait: begin
          if (!i_wb_cyc) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
              rdt_q   <= mem_q[idx];
            end
          end
        end
        StAck: begin
          ack_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Writes commit on the edge leaving ACK; rdt already holds the pre-write word.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_q == StAck && i_wb_we) begin
      for (int n = 0; n < 4; n++) begin
        if (i_wb_sel[n]) mem_q[idx][8*n +: 8] <= i_wb_dat[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_qerv_dbus_ram.sv
// Bench for qerv_dbus_ram: one instance with no wait states, one with three,
// checked against vector tables, hand sequences and a word-array reference model.
module tb_qerv_dbus_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic        cyc0 = 1'b0;
  logic        cyc3 = 1'b0;
  logic [31:0] rdt0, rdt3;
  logic        ack0, ack3;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] model0 [64];
  logic [31:0] model3 [64];

  always #5 clk = ~clk;

  qerv_dbus_ram #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc0), .o_wb_rdt(rdt0), .o_wb_ack(ack0)
  );

  qerv_dbus_ram #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc3), .o_wb_rdt(rdt3), .o_wb_ack(ack3)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  // Called and returns at a negedge. Drives one transfer on instance d (0 or 3).
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] x,
                      input logic [3:0] s, output logic [31:0] r, output int lat);
    adr = a; dat = x; sel = s; we = w;
    if (d == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
    lat = -1;
    r   = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if ((d == 0) ? ack0 : ack3) begin
        lat = n;
        r   = (d == 0) ? rdt0 : rdt3;
        break;
      end
    end
    cyc0 = 1'b0;
    cyc3 = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, (d == 0) ? ack0 : ack3}, 32'd0);
  endtask

  // Transfer with latency and read-data checks, and reference model update.
  task automatic op(input string name, input int d, input logic w, input logic [31:0] a,
                    input logic [31:0] x, input logic [3:0] s, input logic [31:0] exp);
    logic [31:0] r;
    int          lat;
    int          wi;
    xfer(d, w, a, x, s, r, lat);
    chk({name, "_latency"}, 32'(lat), 32'(d + 1));
    chk({name, "_rdt"}, r, exp);
    wi = int'(a[7:2]);
    if (w) begin
      if (d == 0) model0[wi] = merge(model0[wi], x, s);
      else        model3[wi] = merge(model3[wi], x, s);
    end
  endtask

  initial begin
    vec_t        tbl [12];
    logic        seen;
    logic [31:0] a, x;
    logic [3:0]  s;
    logic        w;
    int          n;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h11223344};
    tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 32'h20,  32'hFFFFFFFF, 4'h0, 32'h11BB33DD};
    tbl[6]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD};
    tbl[7]  = '{1'b1, 32'h104, 32'h12345678, 4'hF, 32'h0};
    tbl[8]  = '{1'b0, 32'h04,  32'h0,        4'hF, 32'h12345678};
    tbl[9]  = '{1'b0, 32'h107, 32'h0,        4'hF, 32'h12345678};
    tbl[10] = '{1'b1, 32'h13,  32'hCAFEF00D, 4'hA, 32'hDEADBEEF};
    tbl[11] = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hCAADF0EF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ack0", {31'd0, ack0}, 32'd0);
    chk("reset_rdt0", rdt0, 32'd0);
    chk("reset_ack3", {31'd0, ack3}, 32'd0);
    chk("reset_rdt3", rdt3, 32'd0);

    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ack0 || ack3) seen = 1'b1;
    end
    chk("idle_no_ack", {31'd0, seen}, 32'd0);

    // Known contents: zeros in dut0, random words in dut3.
    for (int i = 0; i < 64; i++) begin
      model0[i] = 32'h0;
      op("fill0", 0, 1'b1, 32'(i * 4), 32'h0, 4'hF, rdt0 === 'x ? 32'h0 : 32'h0);
    end
    for (int i = 0; i < 64; i++) begin
      logic [31:0] r;
      int          lat;
      x = $urandom;
      xfer(3, 1'b1, 32'(i * 4), x, 4'hF, r, lat);
      chk("fill3_latency", 32'(lat), 32'd4);
      model3[i] = x;
    end

    for (int i = 0; i < 12; i++)
      op("table", 0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].exp_rdt);

    // Randomized transfers against the word-array model, both instances.
    for (int i = 0; i < 120; i++) begin
      int d;
      d = (i % 2 == 0) ? 0 : 3;
      w = 1'($urandom);
      a = 32'($urandom_range(0, 1023));
      x = $urandom;
      s = 4'($urandom);
      op("random", d, w, a, x, s, (d == 0) ? model0[a[7:2]] : model3[a[7:2]]);
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
    end

    // Three wait states, cyc held past ack: one-cycle ack, then low.
    adr = 32'h30; we = 1'b0; sel = 4'hF; cyc3 = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack3) begin n = k; break; end
    end
    chk("ws3_latency", 32'(n), 32'd4);
    chk("ws3_rdt", rdt3, model3[12]);
    @(negedge clk);
    chk("ws3_ack_low_cyc_high", {31'd0, ack3}, 32'd0);
    cyc3 = 1'b0;
    repeat (5) @(negedge clk);

    // Abort: cyc dropped during WAIT, no ack and no write.
    adr = 32'h08; dat = 32'h55555555; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    repeat (2) @(negedge clk);
    cyc3 = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack3) seen = 1'b1;
    end
    chk("abort_no_ack", {31'd0, seen}, 32'd0);
    op("abort_readback", 3, 1'b0, 32'h08, 32'h0, 4'hF, model3[2]);

    // Reset pulsed during WAIT cancels the write.
    adr = 32'h1C; dat = 32'h0BADF00D; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc3 = 1'b0;
    chk("rst_wait_rdt_cleared", rdt3, 32'h0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack3) seen = 1'b1;
    end
    chk("rst_wait_no_ack", {31'd0, seen}, 32'd0);
    op("rst_wait_readback", 3, 1'b0, 32'h1C, 32'h0, 4'hF, model3[7]);
    op("rst_wait_dut0_mem", 0, 1'b0, 32'h10, 32'h0, 4'hF, model0[4]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
